pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer: drives PLL reset, qualifies lock, retries on timeout.
// Holds the core in reset until lock is stable plus a hold window; runs on refclk.
module pll_lock_sequencer #(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int HOLD_CYCLES    = 256,
   parameter int MAX_RETRY      = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       req_reset,
   output logic       pll_rst,
   output logic       core_reset,
   output logic       ready,
   output logic [2:0] retry_count,
   output logic       fault,
   output logic [2:0] state
);

   localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int MAX_B = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] C_RST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] C_STB  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] C_TO   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES - 1);
   localparam logic [2:0]    C_MAXR = 3'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_HOLD      = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_s1;
   logic            r_lock_s;
   logic            r_pll_rst;
   logic            r_core_rst;
   logic            r_ready;
   logic [2:0]      r_retry;
   logic            r_fault;

   state_t          w_nxt;
   logic            w_to;
   logic            w_clr;
   logic [2:0]      w_retry_inc;

   assign w_retry_inc = (r_retry == 3'd7) ? 3'd7 : r_retry + 3'd1;

   // Priority: soft restart, then lock loss, then counter expiry.
   always_comb begin
      w_nxt = r_state;
      w_to  = 1'b0;
      if (req_reset) begin
         w_nxt = S_PLL_RST;
      end else begin
         case (r_state)
            S_PLL_RST: begin
               if (r_cnt == C_RST) w_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (r_lock_s) begin
                  w_nxt = S_STABLE;
               end else if (r_cnt == C_TO) begin
                  w_nxt = S_PLL_RST;
                  w_to  = 1'b1;
               end
            end
            S_STABLE: begin
               if (!r_lock_s)          w_nxt = S_WAIT_LOCK;
               else if (r_cnt == C_STB) w_nxt = S_HOLD;
            end
            S_HOLD: begin
               if (!r_lock_s)           w_nxt = S_PLL_RST;
               else if (r_cnt == C_HOLD) w_nxt = S_RUN;
            end
            S_RUN: begin
               if (!r_lock_s) w_nxt = S_PLL_RST;
            end
            default: w_nxt = S_PLL_RST;
         endcase
      end
   end

   assign w_clr = req_reset || (w_nxt != r_state);

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1       <= 1'b0;
         r_lock_s   <= 1'b0;
         r_state    <= S_PLL_RST;
         r_cnt      <= '0;
         r_pll_rst  <= 1'b1;
         r_core_rst <= 1'b1;
         r_ready    <= 1'b0;
         r_retry    <= 3'd0;
         r_fault    <= 1'b0;
      end else begin
         r_s1       <= pll_locked;
         r_lock_s   <= r_s1;
         r_state    <= w_nxt;
         if (w_clr)               r_cnt <= '0;
         else if (r_state != S_RUN) r_cnt <= r_cnt + 1'b1;
         r_pll_rst  <= (w_nxt == S_PLL_RST);
         r_core_rst <= (w_nxt != S_RUN);
         r_ready    <= (w_nxt == S_RUN);
         if (req_reset) begin
            r_retry <= 3'd0;
            r_fault <= 1'b0;
         end else if (w_to) begin
            r_retry <= w_retry_inc;
            if (w_retry_inc >= C_MAXR) r_fault <= 1'b1;
         end
      end
   end

   assign pll_rst     = r_pll_rst;
   assign core_reset  = r_core_rst;
   assign ready       = r_ready;
   assign retry_count = r_retry;
   assign fault       = r_fault;
   assign state       = r_state;

endmodule
